// File: rtl/charmap_pkg.sv
// Shared definitions for the scrolling character-map renderer: default
// geometry, the transparent background index and the encodings used on the
// scroll register write port.
package charmap_pkg;

   localparam int          COLS_LOG2_DEF   = 6;
   localparam int          ROWS_LOG2_DEF   = 6;
   localparam int          CHAR_H_LOG2_DEF = 3;
   localparam logic [7:0]  TRANSP_IDX_DEF  = 8'hFF;

   typedef enum logic [1:0] {
      SEL_SCROLL_X = 2'd0,
      SEL_SCROLL_Y = 2'd1,
      SEL_FLAGS    = 2'd2,
      SEL_RSVD     = 2'd3
   } scroll_sel_e;

   // Bit order matches scroll_data[2:0] on a flags write.
   typedef struct packed {
      logic flip_y;
      logic flip_x;
      logic char_bank;
   } scroll_flags_t;

endpackage

// File: rtl/charmap_scroll_regs.sv
// Scroll register bank. Writes land in the pending copy; the active copy
// (the one the renderer uses) reloads from pending on each vblank rising
// edge, so mid-frame writes never tear the picture.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   vblank_i        vertical blank
//   wr_i/sel_i/data_i  write strobe, register select, write data
//   scroll_x_o/scroll_y_o/flags_o  active register values
module charmap_scroll_regs
   import charmap_pkg::*;
#(
   parameter int XW = 9,
   parameter int YW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          vblank_i,
   input  logic          wr_i,
   input  logic [1:0]    sel_i,
   input  logic [8:0]    data_i,
   output logic [XW-1:0] scroll_x_o,
   output logic [YW-1:0] scroll_y_o,
   output scroll_flags_t flags_o
);

   logic [XW-1:0] pend_x_q, pend_x_d, act_x_q;
   logic [YW-1:0] pend_y_q, pend_y_d, act_y_q;
   scroll_flags_t pend_f_q, pend_f_d, act_f_q;
   logic          vb_prev_q;
   logic          vb_rise;

   assign vb_rise = vblank_i & ~vb_prev_q;

   always_comb begin
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      pend_f_d = pend_f_q;
      if (wr_i) begin
         case (scroll_sel_e'(sel_i))
            SEL_SCROLL_X: pend_x_d = XW'(data_i);
            SEL_SCROLL_Y: pend_y_d = YW'(data_i);
            SEL_FLAGS:    pend_f_d = scroll_flags_t'(data_i[2:0]);
            default:      ;
         endcase
      end
   end

   // Active copy loads from the _d values so a write on the rising edge of
   // vblank is picked up immediately.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pend_x_q  <= '0;
         pend_y_q  <= '0;
         pend_f_q  <= '0;
         act_x_q   <= '0;
         act_y_q   <= '0;
         act_f_q   <= '0;
         vb_prev_q <= 1'b0;
      end else begin
         pend_x_q  <= pend_x_d;
         pend_y_q  <= pend_y_d;
         pend_f_q  <= pend_f_d;
         vb_prev_q <= vblank_i;
         if (vb_rise) begin
            act_x_q <= pend_x_d;
            act_y_q <= pend_y_d;
            act_f_q <= pend_f_d;
         end
      end
   end

   assign scroll_x_o = act_x_q;
   assign scroll_y_o = act_y_q;
   assign flags_o    = act_f_q;

endmodule

// File: rtl/charmap_scroll.sv
// Scrolling character-map renderer. Four-stage pipeline:
//   0: raster + scroll -> char/colour RAM address (combinational)
//   1: char code + glyph line -> CHROM address
//   2: glyph bit select -> palette address (fg or bg index)
//   3: palette colour -> registered r/g/b/a/de_out
// Output appears exactly 4 clocks after hcnt/vcnt/de are presented.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   hcnt, vcnt, de, vblank     raster timing
//   chram_addr / *_data_out    char, fg and bg RAMs (1-cycle read)
//   chrom_addr / chrom_data_out  glyph ROM (1-cycle read)
//   charpaletteram_*           palette RAM, {b,g,r} (1-cycle read)
//   scroll_wr/sel/data         scroll register write port
//   r, g, b, a, de_out         pixel output
module charmap_scroll
   import charmap_pkg::*;
#(
   parameter int         COLS_LOG2   = COLS_LOG2_DEF,
   parameter int         ROWS_LOG2   = ROWS_LOG2_DEF,
   parameter int         CHAR_H_LOG2 = CHAR_H_LOG2_DEF,
   parameter logic [7:0] TRANSP_IDX  = TRANSP_IDX_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [8:0]                     hcnt,
   input  logic [8:0]                     vcnt,
   input  logic                           de,
   input  logic                           vblank,
   output logic [COLS_LOG2+ROWS_LOG2-1:0] chram_addr,
   input  logic [7:0]                     chmap_data_out,
   input  logic [7:0]                     fgcolram_data_out,
   input  logic [7:0]                     bgcolram_data_out,
   output logic [9+CHAR_H_LOG2-1:0]       chrom_addr,
   input  logic [7:0]                     chrom_data_out,
   output logic [7:0]                     charpaletteram_addr_rd,
   input  logic [23:0]                    charpaletteram_data_out,
   input  logic                           scroll_wr,
   input  logic [1:0]                     scroll_sel,
   input  logic [8:0]                     scroll_data,
   output logic [7:0]                     r,
   output logic [7:0]                     g,
   output logic [7:0]                     b,
   output logic                           a,
   output logic                           de_out
);

   localparam int PXW = COLS_LOG2 + 3;
   localparam int PYW = ROWS_LOG2 + CHAR_H_LOG2;

   logic [PXW-1:0] scroll_x;
   logic [PYW-1:0] scroll_y;
   scroll_flags_t  flags;

   charmap_scroll_regs #(
      .XW (PXW),
      .YW (PYW)
   ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .vblank_i   (vblank),
      .wr_i       (scroll_wr),
      .sel_i      (scroll_sel),
      .data_i     (scroll_data),
      .scroll_x_o (scroll_x),
      .scroll_y_o (scroll_y),
      .flags_o    (flags)
   );

   // Stage 0: natural wrap of the truncated adders gives the modulo-map scroll.
   logic [PXW-1:0]         px;
   logic [PYW-1:0]         py;
   logic [CHAR_H_LOG2-1:0] line_d;

   assign px         = PXW'(hcnt) + scroll_x;
   assign py         = PYW'(vcnt) + scroll_y;
   assign chram_addr = {py[PYW-1:CHAR_H_LOG2], px[PXW-1:3]};
   assign line_d     = flags.flip_y ? ~py[CHAR_H_LOG2-1:0] : py[CHAR_H_LOG2-1:0];

   // Per-pixel controls are captured at stage 0 and travel with the pixel,
   // so a register reload never splits one pixel across two settings.
   logic [CHAR_H_LOG2-1:0] line_q;
   logic                   bank_q;
   logic [2:0]             px_lo_q1, px_lo_q2;
   logic                   flip_x_q1, flip_x_q2;
   logic                   de_q1, de_q2, de_q3;
   logic [7:0]             fg_q, bg_q;
   logic                   pix_q;
   logic                   bg_transp_q;

   // Stage 1
   assign chrom_addr = {bank_q, chmap_data_out, line_q};

   // Stage 2: ~x == 7-x on three bits (MSB is the leftmost pixel).
   logic [2:0] bit_sel;
   logic       pix_bit;

   assign bit_sel                = flip_x_q2 ? px_lo_q2 : ~px_lo_q2;
   assign pix_bit                = chrom_data_out[bit_sel];
   assign charpaletteram_addr_rd = pix_bit ? fg_q : bg_q;

   // Stage 3
   logic [7:0] r_q, g_q, b_q, r_d, g_d, b_d;
   logic       a_q, a_d, de_out_q;

   always_comb begin
      r_d = 8'd0;
      g_d = 8'd0;
      b_d = 8'd0;
      a_d = 1'b0;
      if (de_q3) begin
         {b_d, g_d, r_d} = charpaletteram_data_out;
         a_d             = pix_q | ~bg_transp_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         line_q      <= '0;
         bank_q      <= 1'b0;
         px_lo_q1    <= '0;
         px_lo_q2    <= '0;
         flip_x_q1   <= 1'b0;
         flip_x_q2   <= 1'b0;
         de_q1       <= 1'b0;
         de_q2       <= 1'b0;
         de_q3       <= 1'b0;
         fg_q        <= '0;
         bg_q        <= '0;
         pix_q       <= 1'b0;
         bg_transp_q <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         a_q         <= 1'b0;
         de_out_q    <= 1'b0;
      end else begin
         line_q      <= line_d;
         bank_q      <= flags.char_bank;
         px_lo_q1    <= px[2:0];
         flip_x_q1   <= flags.flip_x;
         de_q1       <= de;
         px_lo_q2    <= px_lo_q1;
         flip_x_q2   <= flip_x_q1;
         de_q2       <= de_q1;
         fg_q        <= fgcolram_data_out;
         bg_q        <= bgcolram_data_out;
         pix_q       <= pix_bit;
         bg_transp_q <= (bg_q == TRANSP_IDX);
         de_q3       <= de_q2;
         r_q         <= r_d;
         g_q         <= g_d;
         b_q         <= b_d;
         a_q         <= a_d;
         de_out_q    <= de_q3;
      end
   end

   assign r      = r_q;
   assign g      = g_q;
   assign b      = b_q;
   assign a      = a_q;
   assign de_out = de_out_q;

endmodule

// File: tb/tb_charmap_scroll.sv
module tb_charmap_scroll;

   logic        clk;
   logic        reset;
   logic [8:0]  hcnt, vcnt;
   logic        de, vblank;
   logic [11:0] chram_addr;
   logic [7:0]  chmap_data_out, fgcolram_data_out, bgcolram_data_out;
   logic [11:0] chrom_addr;
   logic [7:0]  chrom_data_out;
   logic [7:0]  charpaletteram_addr_rd;
   logic [23:0] charpaletteram_data_out;
   logic        scroll_wr;
   logic [1:0]  scroll_sel;
   logic [8:0]  scroll_data;
   logic [7:0]  r, g, b;
   logic        a, de_out;

   charmap_scroll dut (
      .clk                     (clk),
      .reset                   (reset),
      .hcnt                    (hcnt),
      .vcnt                    (vcnt),
      .de                      (de),
      .vblank                  (vblank),
      .chram_addr              (chram_addr),
      .chmap_data_out          (chmap_data_out),
      .fgcolram_data_out       (fgcolram_data_out),
      .bgcolram_data_out       (bgcolram_data_out),
      .chrom_addr              (chrom_addr),
      .chrom_data_out          (chrom_data_out),
      .charpaletteram_addr_rd  (charpaletteram_addr_rd),
      .charpaletteram_data_out (charpaletteram_data_out),
      .scroll_wr               (scroll_wr),
      .scroll_sel              (scroll_sel),
      .scroll_data             (scroll_data),
      .r                       (r),
      .g                       (g),
      .b                       (b),
      .a                       (a),
      .de_out                  (de_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memories around the DUT, all with one-cycle read latency.
   logic [7:0]  chmap [4096];
   logic [7:0]  fgm   [4096];
   logic [7:0]  bgm   [4096];
   logic [7:0]  chrom [4096];
   logic [23:0] pal   [256];

   always @(posedge clk) begin
      chmap_data_out          <= chmap[chram_addr];
      fgcolram_data_out       <= fgm[chram_addr];
      bgcolram_data_out       <= bgm[chram_addr];
      chrom_data_out          <= chrom[chrom_addr];
      charpaletteram_data_out <= pal[charpaletteram_addr_rd];
   end

   // Behavioural reference: one entry per pixel, computed from the raster
   // position and the scroll registers in force, then aged 4 clocks.
   typedef struct packed {
      logic        valid;
      logic        de;
      logic        a;
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [7:0]  paddr;
      logic [11:0] caddr;
   } exp_t;

   exp_t        pipe [4];
   int          pend_x, pend_y, pend_f, act_x, act_y, act_f;
   bit          prev_vb;
   bit          known;
   int          n_checks, n_err;
   logic [11:0] last_caddr;

   function automatic int map_addr(int h, int v);
      int px, py;
      px = (h + act_x) % 512;
      py = (v + act_y) % 512;
      return (py / 8) * 64 + px / 8;
   endfunction

   function automatic exp_t model_pix(int h, int v, bit d);
      exp_t e;
      int px, py, addr, line, gl, bank, ch, glyph, bp, bitv, pa;
      logic [23:0] col;
      px    = (h + act_x) % 512;
      py    = (v + act_y) % 512;
      addr  = map_addr(h, v);
      line  = py % 8;
      gl    = ((act_f & 4) != 0) ? 7 - line : line;
      bank  = act_f & 1;
      ch    = int'(chmap[addr]);
      glyph = int'(chrom[bank * 2048 + ch * 8 + gl]);
      bp    = ((act_f & 2) != 0) ? px % 8 : 7 - px % 8;
      bitv  = (glyph >> bp) & 1;
      pa    = (bitv != 0) ? int'(fgm[addr]) : int'(bgm[addr]);
      col   = pal[pa];
      e       = '0;
      e.valid = 1'b1;
      e.de    = d;
      e.paddr = 8'(pa);
      e.caddr = 12'(bank * 2048 + ch * 8 + gl);
      if (d) begin
         e.r = col[7:0];
         e.g = col[15:8];
         e.b = col[23:16];
         e.a = (bitv != 0) || (bgm[addr] != 8'hFF);
      end
      return e;
   endfunction

   task automatic check(input string nm, input logic [39:0] got, input logic [39:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, model the edge, check at the next negedge.
   task automatic step(input int h, input int v, input bit d, input bit vb,
                       input bit wr, input int sel, input int data, input bit rst);
      exp_t e;
      hcnt        = 9'(h);
      vcnt        = 9'(v);
      de          = d;
      vblank      = vb;
      scroll_wr   = wr;
      scroll_sel  = 2'(sel);
      scroll_data = 9'(data);
      reset       = rst;
      e = model_pix(h, v, d);
      #1;
      last_caddr = chram_addr;
      if (known) check("chram_addr", 40'(chram_addr), 40'(map_addr(h, v)));
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 4; i++) pipe[i] = '0;
         pend_x = 0; pend_y = 0; pend_f = 0;
         act_x = 0; act_y = 0; act_f = 0;
         prev_vb = 1'b0;
         known = 1'b1;
      end else begin
         pipe[3] = pipe[2];
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = e;
         if (wr) begin
            case (sel)
               0: pend_x = data % 512;
               1: pend_y = data % 512;
               2: pend_f = data % 8;
               default: ;
            endcase
         end
         if (vb && !prev_vb) begin
            act_x = pend_x; act_y = pend_y; act_f = pend_f;
         end
         prev_vb = vb;
      end
      @(negedge clk);
      if (known) begin
         check("pixel", 40'({de_out, a, r, g, b}),
               40'({pipe[3].de, pipe[3].a, pipe[3].r, pipe[3].g, pipe[3].b}));
         if (pipe[0].valid) check("chrom_addr", 40'(chrom_addr), 40'(pipe[0].caddr));
         if (pipe[1].valid) check("pal_addr", 40'(charpaletteram_addr_rd), 40'(pipe[1].paddr));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Write all three registers, the last one on the vblank rising edge.
   task automatic load(input int sx, input int sy, input int fl);
      step(0, 0, 0, 0, 1, 0, sx, 1);
      step(0, 0, 0, 0, 1, 1, sy, 1);
      step(0, 0, 0, 1, 1, 2, fl, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // In-flight lookups predate a memory edit, so stop cross-checking them.
   task automatic mem_edited();
      for (int i = 0; i < 4; i++) pipe[i].valid = 1'b0;
   endtask

   bit vb_state;

   initial begin
      n_checks = 0; n_err = 0; known = 1'b0;
      for (int i = 0; i < 4; i++) pipe[i] = '0;
      pend_x = 0; pend_y = 0; pend_f = 0; act_x = 0; act_y = 0; act_f = 0;
      prev_vb = 1'b0;
      reset = 1'b0; hcnt = '0; vcnt = '0; de = 1'b0; vblank = 1'b0;
      scroll_wr = 1'b0; scroll_sel = '0; scroll_data = '0;
      for (int i = 0; i < 4096; i++) begin
         chmap[i] = 8'($urandom);
         fgm[i]   = 8'($urandom);
         bgm[i]   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         chrom[i] = 8'($urandom);
      end
      for (int i = 0; i < 256; i++) pal[i] = 24'($urandom);
      chmap[0] = 8'h41; fgm[0] = 8'h12; bgm[0] = 8'h34;
      chrom[12'h41 * 8] = 8'h80;
      pal[8'h12] = 24'h00FF00; pal[8'h34] = 24'h123456;

      @(negedge clk);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("reset_out", 40'({de_out, a, r, g, b}), 40'd0);
      idle(2);

      // Basic pixel: fg colour green, opaque.
      step(0, 0, 1, 0, 0, 0, 0, 1);
      idle(3);
      check("basic_pix", 40'({de_out, a, r, g, b}), 40'({1'b1, 1'b1, 8'h00, 8'hFF, 8'h00}));

      // Background pixel, then transparent background.
      step(1, 0, 1, 0, 0, 0, 0, 1);
      idle(1);
      check("bg_paddr", 40'(charpaletteram_addr_rd), 40'h34);
      idle(2);
      check("bg_opaque", 40'({de_out, a, r, g, b}), 40'({1'b1, 1'b1, 24'h563412}));
      bgm[0] = 8'hFF; mem_edited();
      step(1, 0, 1, 0, 0, 0, 0, 1);
      idle(3);
      check("bg_transp", 40'({de_out, a}), 40'b10);
      bgm[0] = 8'h34; mem_edited();

      // Mid-frame write is held until vblank rises.
      step(0, 0, 0, 0, 1, 0, 8, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      check("midframe_addr", 40'(last_caddr), 40'd0);
      idle(3);
      check("midframe_pix", 40'({de_out, a, r, g, b}), 40'({1'b1, 1'b1, 8'h00, 8'hFF, 8'h00}));
      step(0, 0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      check("after_vb_addr", 40'(last_caddr), 40'd1);

      // Wrap-around at both map edges.
      load(504, 511, 0);
      step(8, 0, 1, 0, 0, 0, 0, 1);
      check("wrap_y_last", 40'(last_caddr), 40'd4032);
      step(8, 1, 1, 0, 0, 0, 0, 1);
      check("wrap_xy_zero", 40'(last_caddr), 40'd0);
      step(7, 1, 1, 0, 0, 0, 0, 1);
      check("wrap_x_last", 40'(last_caddr), 40'd63);

      // Flips.
      load(0, 0, 2);
      idle(3);
      chrom[12'h41 * 8] = 8'h01; mem_edited();
      step(0, 0, 1, 0, 0, 0, 0, 1);
      idle(1);
      check("flipx_paddr", 40'(charpaletteram_addr_rd), 40'h12);
      idle(2);
      check("flipx_pix", 40'({de_out, a, g}), 40'({1'b1, 1'b1, 8'hFF}));
      load(0, 0, 4);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      check("flipy_chrom", 40'(chrom_addr), 40'h20F);
      chrom[12'h41 * 8] = 8'h80;
      idle(3);
      mem_edited();

      // Reset mid-line.
      load(8, 0, 0);
      for (int i = 10; i < 14; i++) step(i, 0, 1, 0, 0, 0, 0, 1);
      step(14, 0, 1, 0, 0, 0, 0, 0);
      check("rst_out", 40'({de_out, a, r, g, b}), 40'd0);
      step(0, 0, 1, 0, 0, 0, 0, 1);
      check("rst_scroll", 40'(last_caddr), 40'd0);
      check("refill_1", 40'(de_out), 40'd0);
      step(1, 0, 1, 0, 0, 0, 0, 1);
      check("refill_2", 40'(de_out), 40'd0);
      step(2, 0, 1, 0, 0, 0, 0, 1);
      check("refill_3", 40'(de_out), 40'd0);
      step(3, 0, 1, 0, 0, 0, 0, 1);
      check("refill_4", 40'(de_out), 40'd1);

      // Randomized traffic against the model.
      vb_state = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) vb_state = ~vb_state;
         step(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
              ($urandom_range(0, 3) != 0), vb_state,
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 511)), ($urandom_range(0, 299) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

endmodule
